// File: rtl/irq_sequencer.sv
// Interrupt/reset entry sequencer: arbitrates reset, NMI and maskable IRQ channels,
// then runs the three stack pushes and the two-byte vector fetch before handing back a new PC.
module irq_sequencer #(
  parameter int unsigned           N_IRQ        = 4,
  parameter int unsigned           ADDR_WIDTH   = 16,
  parameter int unsigned           REG_WIDTH    = 8,
  parameter logic [ADDR_WIDTH-1:0] IRQ_TBL_BASE = ADDR_WIDTH'(16'hFFE0),
  parameter logic [7:0]            STACK_PAGE   = 8'h01
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rst_req,
  input  logic                  nmi_n,
  input  logic [N_IRQ-1:0]      irq_n,
  input  logic [N_IRQ-1:0]      irq_mask,
  input  logic                  i_flag,
  input  logic                  boundary,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic [REG_WIDTH-1:0]  sp_in,
  input  logic [REG_WIDTH-1:0]  stat_in,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_wdata,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [REG_WIDTH-1:0]  sp_out,
  output logic                  pc_valid,
  output logic [3:0]            src_id
);

  localparam logic [3:0]            SRC_NMI  = 4'd14;
  localparam logic [3:0]            SRC_RST  = 4'd15;
  localparam logic [ADDR_WIDTH-1:0] VEC_TOP  = '1;
  localparam logic [ADDR_WIDTH-1:0] VEC_RST  = VEC_TOP - ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] VEC_NMI  = VEC_TOP - ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] VEC_IRQ0 = VEC_TOP - ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P, S_VEC_LO, S_VEC_HI, S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              src_q, src_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [REG_WIDTH-1:0]    sp_q, sp_d;
  logic [REG_WIDTH-1:0]    stat_q, stat_d;
  logic [ADDR_WIDTH-1:0]   vec_q, vec_d;
  logic [REG_WIDTH-1:0]    lo_q, lo_d;
  logic                    nmi_pend_q, nmi_pend_d;
  logic                    nmi_hist_q;
  logic                    nmi_set;

  logic                    busy_q, busy_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [REG_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic [ADDR_WIDTH-1:0]   pc_out_q, pc_out_d;
  logic [REG_WIDTH-1:0]    sp_out_q, sp_out_d;
  logic                    pc_valid_q, pc_valid_d;

  logic [N_IRQ-1:0]        irq_pend;
  logic                    irq_any;
  logic [3:0]              irq_idx;

  function automatic logic [ADDR_WIDTH-1:0] vec_of(input logic [3:0] src);
    logic [ADDR_WIDTH-1:0] v;
    if (src == SRC_RST)      v = VEC_RST;
    else if (src == SRC_NMI) v = VEC_NMI;
    else if (src == 4'd0)    v = VEC_IRQ0;
    else                     v = IRQ_TBL_BASE + (ADDR_WIDTH'(src - 4'd1) << 1);
    return v;
  endfunction

  assign nmi_set  = nmi_hist_q & ~nmi_n;
  assign irq_pend = ~irq_n & irq_mask & {N_IRQ{~i_flag}};

  // Lowest pending channel index wins.
  always_comb begin
    irq_any = 1'b0;
    irq_idx = 4'd0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (irq_pend[i]) begin
        irq_any = 1'b1;
        irq_idx = 4'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and datapath capture.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    pc_d       = pc_q;
    sp_d       = sp_q;
    stat_d     = stat_q;
    vec_d      = vec_q;
    lo_d       = lo_q;
    nmi_pend_d = nmi_pend_q | nmi_set;
    case (state_q)
      S_IDLE: begin
        if (rst_req || (boundary && (nmi_pend_q || irq_any))) begin
          state_d = S_PUSH_PCH;
          pc_d    = pc_in;
          sp_d    = sp_in;
          stat_d  = stat_in;
          if (rst_req) begin
            src_d = SRC_RST;
          end else if (nmi_pend_q) begin
            src_d      = SRC_NMI;
            nmi_pend_d = nmi_set;
          end else begin
            src_d = irq_idx;
          end
        end
      end
      S_PUSH_PCH, S_PUSH_PCL: begin
        if (mem_ack) begin
          state_d = (state_q == S_PUSH_PCH) ? S_PUSH_PCL : S_PUSH_P;
          sp_d    = sp_q - REG_WIDTH'(1);
        end
      end
      S_PUSH_P: begin
        if (mem_ack) begin
          state_d = S_VEC_LO;
          sp_d    = sp_q - REG_WIDTH'(1);
          // A pending NMI takes over an IRQ entry up to the vector fetch.
          if (src_q < SRC_NMI && nmi_pend_q) begin
            src_d      = SRC_NMI;
            nmi_pend_d = nmi_set;
          end
          vec_d = vec_of(src_d);
        end
      end
      S_VEC_LO: begin
        if (mem_ack) begin
          state_d = S_VEC_HI;
          lo_d    = mem_rdata;
        end
      end
      S_VEC_HI: if (mem_ack) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output values for the coming state, registered below.
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    pc_valid_d  = (state_d == S_DONE);
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    pc_out_d    = pc_out_q;
    sp_out_d    = sp_out_q;
    case (state_d)
      S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P: begin
        mem_req_d  = 1'b1;
        mem_we_d   = (src_d != SRC_RST);
        mem_addr_d = ADDR_WIDTH'({STACK_PAGE, sp_d});
      end
      S_VEC_LO: begin
        mem_req_d  = 1'b1;
        mem_addr_d = vec_d;
      end
      S_VEC_HI: begin
        mem_req_d  = 1'b1;
        mem_addr_d = vec_d + ADDR_WIDTH'(1);
      end
      S_DONE: begin
        pc_out_d = ADDR_WIDTH'({mem_rdata, lo_q});
        sp_out_d = sp_d;
      end
      default: ;
    endcase
    if (mem_we_d) begin
      case (state_d)
        S_PUSH_PCH: mem_wdata_d = REG_WIDTH'(pc_d >> REG_WIDTH);
        S_PUSH_PCL: mem_wdata_d = REG_WIDTH'(pc_d);
        default:    mem_wdata_d = (stat_d & ~REG_WIDTH'(8'h10)) | REG_WIDTH'(8'h20);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q       <= '0;
      pc_q        <= '0;
      sp_q        <= '0;
      stat_q      <= '0;
      vec_q       <= '0;
      lo_q        <= '0;
      nmi_pend_q  <= 1'b0;
      nmi_hist_q  <= 1'b1;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      pc_out_q    <= '0;
      sp_out_q    <= '0;
      pc_valid_q  <= 1'b0;
    end else begin
      src_q       <= src_d;
      pc_q        <= pc_d;
      sp_q        <= sp_d;
      stat_q      <= stat_d;
      vec_q       <= vec_d;
      lo_q        <= lo_d;
      nmi_pend_q  <= nmi_pend_d;
      nmi_hist_q  <= nmi_n;
      busy_q      <= busy_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      pc_out_q    <= pc_out_d;
      sp_out_q    <= sp_out_d;
      pc_valid_q  <= pc_valid_d;
    end
  end

  assign busy      = busy_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc_out    = pc_out_q;
  assign sp_out    = sp_out_q;
  assign pc_valid  = pc_valid_q;
  assign src_id    = src_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: table of single entry sequences plus hand-timed
// sequences for NMI hijack, memory stalls and reset during a sequence.
module tb_irq_sequencer;

  logic        clk = 1'b0;
  logic        reset, rst_req, nmi_n, i_flag, boundary, mem_ack;
  logic [3:0]  irq_n, irq_mask;
  logic [15:0] pc_in;
  logic [7:0]  sp_in, stat_in, mem_rdata;
  logic        busy, mem_req, mem_we, pc_valid;
  logic [15:0] mem_addr, pc_out;
  logic [7:0]  mem_wdata, sp_out;
  logic [3:0]  src_id;

  int n_cmp = 0;
  int n_err = 0;

  irq_sequencer dut (
    .clk(clk), .reset(reset), .rst_req(rst_req), .nmi_n(nmi_n),
    .irq_n(irq_n), .irq_mask(irq_mask), .i_flag(i_flag), .boundary(boundary),
    .pc_in(pc_in), .sp_in(sp_in), .stat_in(stat_in),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .pc_out(pc_out), .sp_out(sp_out),
    .pc_valid(pc_valid), .src_id(src_id)
  );

  always #5 clk = ~clk;

  // Memory model: every byte reads as the inverted low address byte.
  assign mem_rdata = ~mem_addr[7:0];

  typedef struct packed {
    logic            rst;
    logic            nmi;
    logic [3:0]      irq_n;
    logic [3:0]      mask;
    logic            iflag;
    logic [15:0]     pc;
    logic [7:0]      sp;
    logic [7:0]      stat;
    logic            acc;
    logic            we;
    logic [4:0][15:0] addr;
    logic [2:0][7:0] wd;
    logic [15:0]     pc_o;
    logic [7:0]      sp_o;
    logic [3:0]      src;
  } vec_t;

  vec_t tbl [9];

  function automatic vec_t mk(
    input logic rst, input logic nmi, input logic [3:0] irqn, input logic [3:0] mask,
    input logic iflag, input logic [15:0] pc, input logic [7:0] sp, input logic [7:0] stat,
    input logic acc, input logic we,
    input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
    input logic [15:0] a3, input logic [15:0] a4,
    input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
    input logic [15:0] pco, input logic [7:0] spo, input logic [3:0] src);
    vec_t v;
    v.rst = rst; v.nmi = nmi; v.irq_n = irqn; v.mask = mask; v.iflag = iflag;
    v.pc = pc; v.sp = sp; v.stat = stat; v.acc = acc; v.we = we;
    v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2; v.addr[3] = a3; v.addr[4] = a4;
    v.wd[0] = w0; v.wd[1] = w1; v.wd[2] = w2;
    v.pc_o = pco; v.sp_o = spo; v.src = src;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_busy(input int lim, output logic seen);
    int n;
    n = 0;
    seen = 1'b0;
    while (!seen && n < lim) begin
      @(negedge clk);
      seen = busy;
      n++;
    end
  endtask

  task automatic wait_pcv(input int lim, output logic seen, output int cyc);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < lim) begin
      @(negedge clk);
      cyc++;
      seen = pc_valid;
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic        seen, done;
    int          cyc, na;
    logic [15:0] la [5];
    logic        lw [5];
    logic [7:0]  ld [5];
    for (int i = 0; i < 5; i++) begin
      la[i] = '0; lw[i] = 1'b0; ld[i] = '0;
    end
    @(posedge clk); #1;
    rst_req = v.rst; irq_n = v.irq_n; irq_mask = v.mask; i_flag = v.iflag;
    pc_in = v.pc; sp_in = v.sp; stat_in = v.stat; boundary = 1'b1; nmi_n = ~v.nmi;
    wait_busy(4, seen);
    check($sformatf("v%0d_accept", id), 32'(seen), 32'(v.acc));
    rst_req = 1'b0; irq_n = '1; boundary = 1'b0; nmi_n = 1'b1;
    if (seen) begin
      na = 0; done = 1'b0; cyc = 0;
      while (!done && cyc < 20) begin
        if (mem_req && mem_ack) begin
          if (na < 5) begin
            la[na] = mem_addr; lw[na] = mem_we; ld[na] = mem_wdata;
          end
          na++;
        end
        if (pc_valid) done = 1'b1;
        else begin
          @(negedge clk);
          cyc++;
        end
      end
      check($sformatf("v%0d_latency", id), 32'(cyc), 32'd5);
      check($sformatf("v%0d_n_access", id), 32'(na), 32'd5);
      for (int i = 0; i < 5; i++) begin
        check($sformatf("v%0d_addr%0d", id, i), 32'(la[i]), 32'(v.addr[i]));
        check($sformatf("v%0d_we%0d", id, i), 32'(lw[i]), (i < 3) ? 32'(v.we) : 32'd0);
        if (i < 3 && v.we)
          check($sformatf("v%0d_wdata%0d", id, i), 32'(ld[i]), 32'(v.wd[i]));
      end
      check($sformatf("v%0d_pc_out", id), 32'(pc_out), 32'(v.pc_o));
      check($sformatf("v%0d_sp_out", id), 32'(sp_out), 32'(v.sp_o));
      check($sformatf("v%0d_src_id", id), 32'(src_id), 32'(v.src));
      @(negedge clk);
      check($sformatf("v%0d_idle", id), {30'd0, busy, pc_valid}, 32'd0);
      check($sformatf("v%0d_pc_hold", id), 32'(pc_out), 32'(v.pc_o));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int   cyc;

    tbl[0] = mk(0, 1, 4'hF, 4'h0, 0, 16'hC123, 8'hFF, 8'h81, 1, 1,
                16'h01FF, 16'h01FE, 16'h01FD, 16'hFFFA, 16'hFFFB,
                8'hC1, 8'h23, 8'hA1, 16'h0405, 8'hFC, 4'd14);
    tbl[1] = mk(0, 0, 4'b0101, 4'hF, 0, 16'h1234, 8'h80, 8'h00, 1, 1,
                16'h0180, 16'h017F, 16'h017E, 16'hFFE0, 16'hFFE1,
                8'h12, 8'h34, 8'h20, 16'h1E1F, 8'h7D, 4'd1);
    tbl[2] = mk(0, 0, 4'b0101, 4'hF, 1, 16'h1234, 8'h80, 8'h00, 0, 0,
                16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0, 8'h0, 16'h0, 8'h0, 4'd0);
    tbl[3] = mk(1, 0, 4'hF, 4'h0, 0, 16'h5555, 8'h00, 8'hFF, 1, 0,
                16'h0100, 16'h01FF, 16'h01FE, 16'hFFFC, 16'hFFFD,
                8'h0, 8'h0, 8'h0, 16'h0203, 8'hFD, 4'd15);
    tbl[4] = mk(0, 0, 4'b1110, 4'hF, 0, 16'h8001, 8'h10, 8'h04, 1, 1,
                16'h0110, 16'h010F, 16'h010E, 16'hFFFE, 16'hFFFF,
                8'h80, 8'h01, 8'h24, 16'h0001, 8'h0D, 4'd0);
    tbl[5] = mk(0, 0, 4'b0000, 4'b1000, 0, 16'h0000, 8'h01, 8'h10, 1, 1,
                16'h0101, 16'h0100, 16'h01FF, 16'hFFE4, 16'hFFE5,
                8'h00, 8'h00, 8'h20, 16'h1A1B, 8'hFE, 4'd3);
    tbl[6] = mk(0, 0, 4'b0000, 4'b0000, 0, 16'h0000, 8'h01, 8'h10, 0, 0,
                16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 8'h0, 8'h0, 8'h0, 16'h0, 8'h0, 4'd0);
    tbl[7] = mk(1, 0, 4'b0000, 4'hF, 0, 16'h0000, 8'h40, 8'h00, 1, 0,
                16'h0140, 16'h013F, 16'h013E, 16'hFFFC, 16'hFFFD,
                8'h0, 8'h0, 8'h0, 16'h0203, 8'h3D, 4'd15);
    tbl[8] = mk(0, 0, 4'b1011, 4'hF, 0, 16'hABCD, 8'h20, 8'h00, 1, 1,
                16'h0120, 16'h011F, 16'h011E, 16'hFFE2, 16'hFFE3,
                8'hAB, 8'hCD, 8'h20, 16'h1C1D, 8'h1D, 4'd2);

    reset = 1'b1; rst_req = 1'b0; nmi_n = 1'b1; irq_n = '1; irq_mask = '0;
    i_flag = 1'b0; boundary = 1'b0; mem_ack = 1'b1;
    pc_in = '0; sp_in = '0; stat_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {28'd0, busy, mem_req, mem_we, pc_valid}, 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_pc_out", 32'(pc_out), 32'd0);
    check("rst_sp_out", 32'(sp_out), 32'd0);
    check("rst_src_id", 32'(src_id), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(tbl[i], i);

    // IRQ ch0 hijacked by an NMI during the pushes, then a second NMI edge mid-sequence.
    @(posedge clk); #1;
    irq_n = 4'b1110; irq_mask = 4'hF; i_flag = 1'b0;
    pc_in = 16'h1111; sp_in = 8'h50; stat_in = 8'h00; boundary = 1'b1;
    wait_busy(4, seen);
    check("h1_accept", 32'(seen), 32'd1);
    irq_n = '1; boundary = 1'b0;
    check("h1_pch_addr", 32'(mem_addr), 32'h0150);
    @(negedge clk);
    nmi_n = 1'b0;
    @(negedge clk);
    check("h1_pushp_addr", 32'(mem_addr), 32'h014E);
    check("h1_pushp_data", 32'(mem_wdata), 32'h20);
    nmi_n = 1'b1;
    @(negedge clk);
    check("h1_veclo_addr", 32'(mem_addr), 32'hFFFA);
    check("h1_veclo_we", 32'(mem_we), 32'd0);
    nmi_n = 1'b0;
    @(negedge clk);
    check("h1_vechi_addr", 32'(mem_addr), 32'hFFFB);
    @(negedge clk);
    check("h1_pc_valid", 32'(pc_valid), 32'd1);
    check("h1_pc_out", 32'(pc_out), 32'h0405);
    check("h1_sp_out", 32'(sp_out), 32'h4D);
    check("h1_src_id", 32'(src_id), 32'd14);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("h1_no_boundary%0d", k), 32'(busy), 32'd0);
    end
    pc_in = 16'h2222; sp_in = 8'h30; boundary = 1'b1; nmi_n = 1'b1;
    wait_busy(4, seen);
    check("h1_second_accept", 32'(seen), 32'd1);
    check("h1_second_addr", 32'(mem_addr), 32'h0130);
    check("h1_second_wdata", 32'(mem_wdata), 32'h22);
    check("h1_second_src", 32'(src_id), 32'd14);
    wait_pcv(10, seen, cyc);
    check("h1_second_done", 32'(seen), 32'd1);
    check("h1_second_pc", 32'(pc_out), 32'h0405);
    check("h1_second_sp", 32'(sp_out), 32'h2D);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("h1_pend_clear%0d", k), 32'(busy), 32'd0);
    end
    boundary = 1'b0;

    // Three-cycle memory stall in PUSH_P.
    @(posedge clk); #1;
    irq_n = 4'b1101; pc_in = 16'h4321; sp_in = 8'h90; stat_in = 8'h00; boundary = 1'b1;
    wait_busy(4, seen);
    check("h2_accept", 32'(seen), 32'd1);
    irq_n = '1; boundary = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    check("h2_stall_addr", 32'(mem_addr), 32'h018E);
    check("h2_stall_data", 32'(mem_wdata), 32'h20);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("h2_hold%0d", k), {mem_req, mem_we, mem_wdata, mem_addr},
            {1'b1, 1'b1, 8'h20, 16'h018E});
    end
    mem_ack = 1'b1;
    wait_pcv(10, seen, cyc);
    check("h2_done", 32'(seen), 32'd1);
    check("h2_latency_tail", 32'(cyc), 32'd3);
    check("h2_pc_out", 32'(pc_out), 32'h1E1F);
    check("h2_sp_out", 32'(sp_out), 32'h8D);
    check("h2_src_id", 32'(src_id), 32'd1);

    // Reset pulse while fetching the vector high byte.
    @(posedge clk); #1;
    irq_n = 4'b1110; pc_in = 16'h0000; sp_in = 8'h00; boundary = 1'b1;
    wait_busy(4, seen);
    check("h3_accept", 32'(seen), 32'd1);
    irq_n = '1; boundary = 1'b0;
    repeat (4) @(negedge clk);
    check("h3_vechi_addr", 32'(mem_addr), 32'hFFFF);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("h3_ctrl", {28'd0, busy, mem_req, mem_we, pc_valid}, 32'd0);
    check("h3_addr", 32'(mem_addr), 32'd0);
    check("h3_pc_out", 32'(pc_out), 32'd0);
    check("h3_sp_out", 32'(sp_out), 32'd0);
    check("h3_src_id", 32'(src_id), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("h3_quiet%0d", k), {30'd0, busy, pc_valid}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
